// File: rtl/inst_sequencer.sv
// inst_sequencer: steps a core through one job per start pulse:
// host -> xmem writes, xmem -> L0 loads, execute, ofifo -> pmem drain.
module inst_sequencer #(
    parameter int unsigned row        = 8,
    parameter int unsigned col        = 8,
    parameter int unsigned bw         = 4,
    parameter int unsigned inst_width = 35
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [11:0]             len,
    input  logic [10:0]             x_base,
    input  logic [10:0]             p_base,
    input  logic                    in_valid,
    input  logic [bw*row-1:0]       in_data,
    output logic                    in_ready,
    input  logic                    ofifo_valid,
    output logic [inst_width-1:0]   inst,
    output logic [bw*row-1:0]       D_xmem,
    output logic                    busy,
    output logic                    done
);

    localparam int unsigned data_w = bw * row;

    // The instruction word layout is fixed at 35 bits; wider words are zero-padded.
    if (row == 0 || col == 0 || bw == 0 || inst_width < 35) begin : g_bad_params
        $error("inst_sequencer: illegal parameter set");
    end

    typedef struct packed {
        logic        acc;
        logic        cen_pmem;
        logic        wen_pmem;
        logic [10:0] a_pmem;
        logic        cen_xmem;
        logic        wen_xmem;
        logic [10:0] a_xmem;
        logic        ofifo_rd;
        logic [1:0]  rsvd_hi;
        logic        l0_rd;
        logic        l0_wr;
        logic        execute;
        logic [1:0]  rsvd_lo;
    } inst_t;

    typedef enum logic [2:0] {
        IDLE,
        WR_X,
        LD_L0,
        EXEC,
        DRAIN,
        DONE
    } state_t;

    state_t             state, state_n;
    logic [11:0]        k, k_n;
    logic [11:0]        len_q, len_n;
    logic [10:0]        xb_q, xb_n;
    logic [10:0]        pb_q, pb_n;
    inst_t              word_n;
    logic [34:0]        word_bits;
    logic [data_w-1:0]  d_n;
    logic               done_n;
    logic [11:0]        last_k;

    assign last_k    = 12'(len_q - 12'd1);
    assign word_bits = word_n;

    // State and output registers; every output reflects the previous cycle's decision.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            k        <= '0;
            len_q    <= '0;
            xb_q     <= '0;
            pb_q     <= '0;
            inst     <= inst_width'(35'h3_0018_0000);
            D_xmem   <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_n;
            k        <= k_n;
            len_q    <= len_n;
            xb_q     <= xb_n;
            pb_q     <= pb_n;
            inst     <= inst_width'(word_bits);
            D_xmem   <= d_n;
            in_ready <= (state_n == WR_X);
            busy     <= (state_n != IDLE);
            done     <= done_n;
        end
    end

    // Next-state, counter and instruction-word decode.
    always_comb begin
        state_n         = state;
        k_n             = k;
        len_n           = len_q;
        xb_n            = xb_q;
        pb_n            = pb_q;
        d_n             = '0;
        done_n          = 1'b0;
        word_n          = '0;
        word_n.cen_pmem = 1'b1;
        word_n.wen_pmem = 1'b1;
        word_n.cen_xmem = 1'b1;
        word_n.wen_xmem = 1'b1;

        case (state)
            IDLE: begin
                if (start) begin
                    if (len != 12'd0) begin
                        len_n   = len;
                        xb_n    = x_base;
                        pb_n    = p_base;
                        k_n     = '0;
                        state_n = WR_X;
                    end else begin
                        state_n = DONE;
                    end
                end
            end
            WR_X: begin
                if (in_valid && in_ready) begin
                    word_n.cen_xmem = 1'b0;
                    word_n.wen_xmem = 1'b0;
                    word_n.a_xmem   = 11'(xb_q + k[10:0]);
                    d_n             = in_data;
                    if (k == last_k) begin
                        k_n     = '0;
                        state_n = LD_L0;
                    end else begin
                        k_n = 12'(k + 12'd1);
                    end
                end
            end
            LD_L0: begin
                // Read k while loading the word read on the previous cycle.
                if (k < len_q) begin
                    word_n.cen_xmem = 1'b0;
                    word_n.a_xmem   = 11'(xb_q + k[10:0]);
                end
                word_n.l0_wr = (k != 12'd0);
                if (k == len_q) begin
                    k_n     = '0;
                    state_n = EXEC;
                end else begin
                    k_n = 12'(k + 12'd1);
                end
            end
            EXEC: begin
                word_n.l0_rd   = 1'b1;
                word_n.execute = 1'b1;
                if (k == last_k) begin
                    k_n     = '0;
                    state_n = DRAIN;
                end else begin
                    k_n = 12'(k + 12'd1);
                end
            end
            DRAIN: begin
                if (ofifo_valid) begin
                    word_n.ofifo_rd = 1'b1;
                    word_n.cen_pmem = 1'b0;
                    word_n.wen_pmem = 1'b0;
                    word_n.a_pmem   = 11'(pb_q + k[10:0]);
                    if (k == last_k) begin
                        k_n     = '0;
                        state_n = DONE;
                    end else begin
                        k_n = 12'(k + 12'd1);
                    end
                end
            end
            DONE: begin
                done_n  = 1'b1;
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule
